// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback-stage register file.
package wb_regfile_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int ADDR_W_DEF = 4;
  localparam int NREGS_DEF  = 15;

  // Address 15 is the virtual PC register and has no storage.
  localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/regfile_core.sv
// Architectural register storage: one synchronous write port, two
// combinational read ports and a synchronous clear.
module regfile_core #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 15,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [WIDTH-1:0]  writeData,
  input  logic [ADDR_W-1:0] readAddr1,
  input  logic [ADDR_W-1:0] readAddr2,
  output logic [WIDTH-1:0]  readData1,
  output logic [WIDTH-1:0]  readData2
);

  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (writeEn && (int'(writeAddr) < NREGS)) begin
      regs[writeAddr] <= writeData;
    end
  end

  // Addresses beyond the physical range read as zero; the wrapper replaces them.
  always_comb begin
    readData1 = '0;
    readData2 = '0;
    if (int'(readAddr1) < NREGS) readData1 = regs[readAddr1];
    if (int'(readAddr2) < NREGS) readData2 = regs[readAddr2];
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, register commit with decode-read bypass,
// R15 substitution, PC redirect and a committed-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteW,
  input  logic              MemtoRegW,
  input  logic              PCSrcW,
  input  logic [ADDR_W-1:0] WA3W,
  input  logic [WIDTH-1:0]  ReadDataW,
  input  logic [WIDTH-1:0]  ALUOutW,
  input  logic [ADDR_W-1:0] RA1D,
  input  logic [ADDR_W-1:0] RA2D,
  input  logic [WIDTH-1:0]  R15D,
  output logic [WIDTH-1:0]  RD1D,
  output logic [WIDTH-1:0]  RD2D,
  output logic [WIDTH-1:0]  ResultW,
  output logic              PCRedirectW,
  output logic [WIDTH-1:0]  PCTargetW,
  output logic [WIDTH-1:0]  WriteCountW
);

  logic             commitW;
  logic [WIDTH-1:0] storeData1;
  logic [WIDTH-1:0] storeData2;
  logic [WIDTH-1:0] writeCount;

  assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

  // Writes to the PC address only redirect fetch; they never reach storage.
  assign commitW = RegWriteW && (WA3W != ADDR_W'(REG_PC));

  regfile_core #(
    .WIDTH  (WIDTH),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) core (
    .clk       (clk),
    .reset     (reset),
    .writeEn   (commitW),
    .writeAddr (WA3W),
    .writeData (ResultW),
    .readAddr1 (RA1D),
    .readAddr2 (RA2D),
    .readData1 (storeData1),
    .readData2 (storeData2)
  );

  // R15 wins over bypass so a PC write in W never leaks into decode operands.
  always_comb begin
    RD1D = storeData1;
    RD2D = storeData2;
    if (RA1D == ADDR_W'(REG_PC)) begin
      RD1D = R15D;
    end else if (commitW && !reset && (WA3W == RA1D)) begin
      RD1D = ResultW;
    end
    if (RA2D == ADDR_W'(REG_PC)) begin
      RD2D = R15D;
    end else if (commitW && !reset && (WA3W == RA2D)) begin
      RD2D = ResultW;
    end
  end

  assign PCRedirectW = PCSrcW && !reset;
  assign PCTargetW   = ResultW;

  always_ff @(posedge clk) begin
    if (reset) begin
      writeCount <= '0;
    end else if (commitW) begin
      writeCount <= writeCount + WIDTH'(1);
    end
  end

  assign WriteCountW = writeCount;

endmodule
